// File: rtl/picorv32_mem_arb_if.sv
// PicoRV32-style native memory bus. The master modport is the side that issues
// requests; the slave modport is the side that answers them.
interface picorv32_mem_arb_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_arb.sv
// Two-master arbiter onto one PicoRV32 memory slave: round-robin or fixed
// priority, registered slave request, optional abort of stalled transfers.
module picorv32_mem_arb #(
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    picorv32_mem_arb_if.slave     m0,
    picorv32_mem_arb_if.slave     m1,
    picorv32_mem_arb_if.master    s,
    output logic                  grant,
    output logic                  timeout
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
    localparam int         CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [0:0]    r_state;
    logic          r_grant;
    logic          r_last;
    logic          r_instr;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic [CW-1:0] r_cnt;

    logic w_busy, w_req_any, w_win, w_expire, w_done, w_abort;

    assign w_busy    = (r_state == S_BUSY);
    assign w_req_any = m0.mem_valid | m1.mem_valid;

    // r_last starts at 1 so m0 takes the first contested round.
    always_comb begin
        if (m0.mem_valid && m1.mem_valid)
            w_win = (PRIO_MODE != 0) ? 1'b0 : ~r_last;
        else
            w_win = ~m0.mem_valid;
    end

    // Counter holds the number of stalled BUSY cycles already elapsed, so the
    // limit hits in the TIMEOUT-th BUSY cycle; slave ready always wins over it.
    assign w_expire = (TIMEOUT > 0) && (r_cnt == CW'(TIMEOUT - 1));
    assign w_done   = w_busy & (s.mem_ready | w_expire);
    assign w_abort  = w_busy & ~s.mem_ready & w_expire;

    assign m0.mem_ready = w_done & ~r_grant;
    assign m1.mem_ready = w_done &  r_grant;
    assign m0.mem_rdata = (w_busy & s.mem_ready & ~r_grant) ? s.mem_rdata : 32'h0;
    assign m1.mem_rdata = (w_busy & s.mem_ready &  r_grant) ? s.mem_rdata : 32'h0;

    assign s.mem_valid = w_busy;
    assign s.mem_instr = r_instr;
    assign s.mem_addr  = r_addr;
    assign s.mem_wdata = r_wdata;
    assign s.mem_wstrb = r_wstrb;
    assign grant       = r_grant;
    assign timeout     = w_abort;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_instr <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wstrb <= 4'h0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_state <= S_BUSY;
                        r_grant <= w_win;
                        r_last  <= w_win;
                        r_cnt   <= '0;
                        r_instr <= w_win ? m1.mem_instr : m0.mem_instr;
                        r_addr  <= w_win ? m1.mem_addr  : m0.mem_addr;
                        r_wdata <= w_win ? m1.mem_wdata : m0.mem_wdata;
                        r_wstrb <= w_win ? m1.mem_wstrb : m0.mem_wstrb;
                    end
                end
                S_BUSY: begin
                    if (w_done)
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_picorv32_mem_arb.sv
// Bench for picorv32_mem_arb: two instances (round-robin with TIMEOUT=8, fixed
// priority without timeout) driven identically and compared to a transfer model.
module tb_picorv32_mem_arb;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    picorv32_mem_arb_if m0a(), m1a(), sa(), m0b(), m1b(), sb();
    logic ga, toa, gb, tob;

    picorv32_mem_arb #(.PRIO_MODE(0), .TIMEOUT(8)) dut_a (
        .clk(clk), .resetn(resetn), .m0(m0a), .m1(m1a), .s(sa), .grant(ga), .timeout(toa));
    picorv32_mem_arb #(.PRIO_MODE(1), .TIMEOUT(0)) dut_b (
        .clk(clk), .resetn(resetn), .m0(m0b), .m1(m1b), .s(sb), .grant(gb), .timeout(tob));

    logic        v0, v1, i0, i1, sr;
    logic [31:0] a0, a1, w0, w1, srd;
    logic [3:0]  s0, s1;
    int errors = 0;
    int checks = 0;

    // Transfer-level view of one arbiter: is a transfer outstanding, whose is
    // it, how many BUSY cycles it has used, and what request was captured.
    typedef struct {
        bit busy; bit last; bit grant; int age;
        bit instr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    } mdl_t;
    mdl_t md[2];
    int prio_of[2];
    int to_of[2];

    function automatic mdl_t mreset();
        mdl_t m;
        m.busy = 0; m.last = 1; m.grant = 0; m.age = 0;
        m.instr = 0; m.addr = 0; m.wdata = 0; m.wstrb = 0;
        return m;
    endfunction

    function automatic bit mdone(input int d);
        return md[d].busy && (sr || (to_of[d] > 0 && md[d].age + 1 == to_of[d]));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        m0a.mem_valid = v0; m0a.mem_instr = i0; m0a.mem_addr = a0; m0a.mem_wdata = w0; m0a.mem_wstrb = s0;
        m1a.mem_valid = v1; m1a.mem_instr = i1; m1a.mem_addr = a1; m1a.mem_wdata = w1; m1a.mem_wstrb = s1;
        sa.mem_ready = sr; sa.mem_rdata = srd;
        m0b.mem_valid = v0; m0b.mem_instr = i0; m0b.mem_addr = a0; m0b.mem_wdata = w0; m0b.mem_wstrb = s0;
        m1b.mem_valid = v1; m1b.mem_instr = i1; m1b.mem_addr = a1; m1b.mem_wdata = w1; m1b.mem_wstrb = s1;
        sb.mem_ready = sr; sb.mem_rdata = srd;
    endtask

    task automatic rnd_fields();
        i0 = 1'($urandom); a0 = $urandom; w0 = $urandom; s0 = 4'($urandom);
        i1 = 1'($urandom); a1 = $urandom; w1 = $urandom; s1 = 4'($urandom);
        srd = $urandom;
    endtask

    task automatic check_dut(input int d, input string p, input logic sv, input logic si,
                             input logic [31:0] sad, input logic [31:0] swd, input logic [3:0] sws,
                             input logic g, input logic to, input logic r0, input logic r1,
                             input logic [31:0] rd0, input logic [31:0] rd1);
        bit dn;
        dn = mdone(d);
        chk({p, ".s_valid"}, sv, md[d].busy);
        chk({p, ".s_instr"}, si, md[d].instr);
        chk({p, ".s_addr"}, sad, md[d].addr);
        chk({p, ".s_wdata"}, swd, md[d].wdata);
        chk({p, ".s_wstrb"}, sws, md[d].wstrb);
        chk({p, ".grant"}, g, md[d].grant);
        chk({p, ".timeout"}, to, dn && !sr);
        chk({p, ".m0_ready"}, r0, dn && !md[d].grant);
        chk({p, ".m1_ready"}, r1, dn && md[d].grant);
        chk({p, ".m0_rdata"}, rd0, (dn && !md[d].grant && sr) ? srd : 32'h0);
        chk({p, ".m1_rdata"}, rd1, (dn && md[d].grant && sr) ? srd : 32'h0);
    endtask

    task automatic check_all();
        check_dut(0, "a", sa.mem_valid, sa.mem_instr, sa.mem_addr, sa.mem_wdata, sa.mem_wstrb,
                  ga, toa, m0a.mem_ready, m1a.mem_ready, m0a.mem_rdata, m1a.mem_rdata);
        check_dut(1, "b", sb.mem_valid, sb.mem_instr, sb.mem_addr, sb.mem_wdata, sb.mem_wstrb,
                  gb, tob, m0b.mem_ready, m1b.mem_ready, m0b.mem_rdata, m1b.mem_rdata);
    endtask

    // Advance each model across the coming rising edge using the current inputs.
    task automatic update_all();
        for (int d = 0; d < 2; d++) begin
            if (md[d].busy) begin
                if (mdone(d)) md[d].busy = 0;
                else md[d].age++;
            end else if (v0 || v1) begin
                bit w;
                if (v0 && v1) w = (prio_of[d] != 0) ? 1'b0 : !md[d].last;
                else w = v1;
                md[d].busy = 1; md[d].age = 0; md[d].grant = w; md[d].last = w;
                md[d].instr = w ? i1 : i0;
                md[d].addr  = w ? a1 : a0;
                md[d].wdata = w ? w1 : w0;
                md[d].wstrb = w ? s1 : s0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1 apply();
        @(negedge clk);
        check_all();
        update_all();
    endtask

    initial begin
        int qa[$];
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};
        prio_of = '{0, 1};
        to_of = '{8, 0};
        v0 = 0; v1 = 0; sr = 0;
        rnd_fields();
        apply();
        md[0] = mreset(); md[1] = mreset();
        #1 check_all();
        @(negedge clk);
        resetn = 1'b1;
        #1 check_all();
        update_all();

        // single read from m0
        v0 = 1; a0 = 32'h100; s0 = 4'h0; sr = 0;
        tick();
        tick();
        chk("rd.s_addr", sa.mem_addr, 32'h100);
        tick();
        tick();
        sr = 1; srd = 32'hDEADBEEF;
        tick();
        chk("rd.m0_rdata", m0a.mem_rdata, 32'hDEADBEEF);
        chk("rd.m0_ready", m0a.mem_ready, 1);
        chk("rd.m1_ready", m1a.mem_ready, 0);
        v0 = 0; sr = 0;
        tick();

        // m1 write held through a long stall while master inputs churn
        v1 = 1; a1 = 32'h2000; w1 = 32'h12345678; s1 = 4'b0011; i1 = 0;
        tick();
        for (int k = 0; k < 11; k++) begin
            sr = 0;
            rnd_fields();
            v1 = 1'($urandom);
            tick();
        end
        chk("wr.s_addr", sb.mem_addr, 32'h2000);
        chk("wr.s_wdata", sb.mem_wdata, 32'h12345678);
        chk("wr.s_wstrb", sb.mem_wstrb, 4'b0011);
        v0 = 0; v1 = 0; sr = 1;
        tick();
        sr = 0;
        tick();
        tick();

        // timeout abort in the 8th BUSY cycle
        v0 = 1;
        tick();
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 8) begin
                chk("to.pulse", toa, 1);
                chk("to.m0_ready", m0a.mem_ready, 1);
                chk("to.m0_rdata", m0a.mem_rdata, 32'h0);
            end
        end
        v0 = 0; sr = 1;
        tick();
        sr = 0;
        tick();

        // slave ready coinciding with the limit wins
        v0 = 1;
        tick();
        for (int n = 1; n <= 8; n++) begin
            sr = (n == 8);
            tick();
            if (n == 8) begin
                chk("coin.timeout", toa, 0);
                chk("coin.m0_rdata", m0a.mem_rdata, srd);
            end
        end
        v0 = 0; sr = 0;
        tick();

        // reset while BUSY, then continuous contention
        v0 = 1; v1 = 0; sr = 0;
        tick();
        tick();
        #2 resetn = 1'b0;
        v0 = 1; v1 = 1; sr = 1; srd = $urandom;
        apply();
        md[0] = mreset(); md[1] = mreset();
        #1 check_all();
        chk("rst.s_valid", sa.mem_valid, 0);
        chk("rst.m0_ready", m0a.mem_ready, 0);
        @(negedge clk);
        resetn = 1'b1;
        #1 check_all();
        update_all();
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sa.mem_valid) qa.push_back(int'(ga));
            if (sb.mem_valid) chk("prio.grant", gb, 0);
        end
        chk("cont.count", qa.size() >= 4, 1);
        for (int k = 0; k < 4 && k < qa.size(); k++)
            chk($sformatf("cont.order%0d", k), qa[k], exp_g[k]);

        // randomized traffic, later with long slave stalls
        for (int it = 0; it < 1500; it++) begin
            v0 = $urandom_range(0, 3) != 0;
            v1 = $urandom_range(0, 3) != 0;
            rnd_fields();
            if (it < 700) sr = $urandom_range(0, 2) == 0;
            else sr = $urandom_range(0, 11) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/picorv32_mem_arb.md
PICORV32_MEM_ARB -- requirements
Module: picorv32_mem_arb

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0, 0=round-robin, 1=fixed priority m0 over m1.
REQ-002 SHALL have parameter TIMEOUT, default 0, slave-wait abort limit in cycles; 0 disables the abort.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports m0_mem_valid/m1_mem_valid  input  1  master request.
REQ-006 SHALL have ports mN_mem_instr  input  1  instruction-fetch flag.
REQ-007 SHALL have ports mN_mem_addr, mN_mem_wdata  input  32  address and write data.
REQ-008 SHALL have ports mN_mem_wstrb  input  4  byte write strobes; 0 means read.
REQ-009 SHALL have ports mN_mem_ready  output  1  transfer-complete pulse to master N.
REQ-010 SHALL have ports mN_mem_rdata  output  32  read data to master N.
REQ-011 SHALL have ports s_mem_valid, s_mem_instr  output  1  slave request and fetch flag.
REQ-012 SHALL have ports s_mem_addr, s_mem_wdata  output  32; s_mem_wstrb  output  4  slave request fields.
REQ-013 SHALL have ports s_mem_ready  input  1; s_mem_rdata  input  32  slave response.
REQ-014 SHALL have port grant  output  1  index of the master owning the current or last transfer.
REQ-015 SHALL have port timeout  output  1  one-cycle pulse when a transfer is aborted.

Function
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 IDLE: if any mN_mem_valid=1, SHALL pick a winner, register its instr/addr/wdata/wstrb into the s_mem_* outputs, set grant, go BUSY; otherwise stay IDLE.
REQ-018 Latency: s_mem_valid SHALL rise exactly 1 cycle after the winning mN_mem_valid is seen in IDLE.
REQ-019 Round-robin: both requesting SHALL pick the master not granted last; a single requester SHALL always win.
REQ-020 PRIO_MODE=1: both requesting SHALL always pick m0.
REQ-021 BUSY: s_mem_* outputs SHALL stay constant until completion, regardless of master inputs changing.
REQ-022 Completion: s_mem_ready=1 in BUSY SHALL drive mN_mem_ready=1 combinationally for the granted master only, in the same cycle.
REQ-023 Completion: mN_mem_rdata SHALL equal s_mem_rdata for the granted master in that cycle.
REQ-024 Completion: s_mem_valid SHALL deassert on the next edge and the FSM SHALL return to IDLE; each transfer is followed by at least one IDLE cycle.
REQ-025 Outside completion, each mN_mem_ready SHALL be 0 and each mN_mem_rdata SHALL be 32'h0.
REQ-026 The non-granted master SHALL never see ready and SHALL wait, with its valid held, for the next arbitration.
REQ-027 TIMEOUT>0: a counter SHALL clear on entering BUSY and increment each BUSY cycle without s_mem_ready.
REQ-028 Timeout abort: when the counter reaches TIMEOUT, the granted master SHALL get ready=1 with rdata=32'h0 and timeout SHALL pulse for that cycle.
REQ-029 After a timeout abort, s_mem_valid SHALL drop and the FSM SHALL return to IDLE.
REQ-030 If s_mem_ready and the timeout condition coincide, s_mem_ready SHALL win: normal completion, no timeout pulse.
REQ-031 The counter SHALL be wide enough for TIMEOUT with no wrap before the limit.
REQ-032 A master that drops valid while granted (protocol violation) SHALL NOT abort the slave transfer; its ready pulse is still issued.

Reset
REQ-033 resetn=0 SHALL immediately force, asynchronously, FSM=IDLE; s_mem_valid, s_mem_instr, s_mem_wstrb=0; s_mem_addr, s_mem_wdata=32'h0; grant=0; timeout=0; counter=0.
REQ-034 resetn=0 mid-transfer SHALL abandon that transfer and issue no ready to either master.
REQ-035 Round-robin history after reset SHALL treat m1 as last granted, so m0 wins the first contested arbitration.
REQ-036 The first arbitration SHALL occur on the first rising edge with resetn=1.

Verification
REQ-037 Single read: m0 requests addr=0x100, wstrb=0; slave asserts ready 3 cycles after s_mem_valid with rdata=0xDEADBEEF -> s_mem_addr=0x100 one cycle after the request; m0_mem_ready pulse with rdata 0xDEADBEEF; m1_mem_ready stays 0.
REQ-038 Contention, PRIO_MODE=0: m0 and m1 request continuously from reset -> grant order 0,1,0,1; each transfer separated by at least one IDLE cycle.
REQ-039 PRIO_MODE=1: m0 and m1 request continuously -> m0 always granted; m1 granted only in an arbitration cycle when m0_mem_valid=0.
REQ-040 Write passthrough: m1 sends wstrb=4'b0011, wdata=0x12345678, addr=0x2000 -> identical values on s_mem_*, held stable for a 10-cycle slave stall.
REQ-041 Timeout: TIMEOUT=8, slave never ready -> in the 8th BUSY cycle, granted master ready=1 with rdata=0 and timeout pulses; then IDLE. With s_mem_ready in that same cycle -> no timeout pulse.
REQ-042 Reset mid-transfer: resetn=0 while BUSY -> all outputs reach reset values without a clock edge; no ready pulse; m0 wins the next contested arbitration.
